// File: rtl/cpu_pkg.sv
// Shared processor package: FSM state encoding for the memory access
// controller, default datapath widths and the wait-counter helper.
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W  default address / data (MBR) widths
//   DEF_WAIT_CYCLES          default memory wait states per access
//   WCNT_W                   width of the wait-state down-counter
//   ST_*                     3-bit FSM state encoding
//   wait_load_value()        value loaded into the wait counter
package cpu_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int WCNT_W          = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The counter is loaded with N-1 so that reaching zero marks the last of
    // N wait cycles; with no wait states WAIT is skipped and the value is unused.
    function automatic logic [WCNT_W-1:0] wait_load_value(input int wait_cycles);
        if (wait_cycles > 0) begin
            return WCNT_W'(wait_cycles - 1);
        end else begin
            return {WCNT_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter for the memory access controller.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (count -> 0)
//   srst     synchronous clear (count -> 0), highest synchronous priority
//   load     load load_val
//   dec      decrement by one; saturates at zero
//   load_val value to load
//   zero     count is zero
module wait_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst,
    input  logic              load,
    input  logic              dec,
    input  logic [WCNT_W-1:0] load_val,
    output logic              zero
);

    logic [WCNT_W-1:0] count_r;

    // Counter register: clear, load or decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WCNT_W{1'b0}};
        end else if (srst) begin
            count_r <= {WCNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {WCNT_W{1'b0}})) begin
            count_r <= count_r - WCNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WCNT_W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller sitting between the MAR/MBR and the memory.
// One request is accepted in IDLE, then SETUP -> WAIT (WAIT_CYCLES cycles,
// skipped when zero) -> ACCESS -> DONE -> IDLE. All outputs are registered
// from the next state, so each output is valid during the state it belongs to.
//
// Ports:
//   MAC_clk, MAC_rst_n          clock, asynchronous active-low reset
//   MAC_req, MAC_rw             request, 1 = write / 0 = read
//   MAC_addr, MAC_wdata         address (MAR) and write data (MBR)
//   MAC_busy, MAC_done          not-IDLE flag, one-cycle completion pulse
//   MAC_mem_en, MAC_mem_we      memory enable and write strobe
//   MAC_mem_addr, MAC_mem_din   memory address and write data
//   MAC_mem_dout                memory read data
//   MAC_mbr_data, MAC_mbr_we    read data to the MBR and its load strobe
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              MAC_clk,
    input  logic              MAC_rst_n,
    input  logic              MAC_req,
    input  logic              MAC_rw,
    input  logic [ADDR_W-1:0] MAC_addr,
    input  logic [DATA_W-1:0] MAC_wdata,
    output logic              MAC_busy,
    output logic              MAC_done,
    output logic              MAC_mem_en,
    output logic              MAC_mem_we,
    output logic [ADDR_W-1:0] MAC_mem_addr,
    output logic [DATA_W-1:0] MAC_mem_din,
    input  logic [DATA_W-1:0] MAC_mem_dout,
    output logic [DATA_W-1:0] MAC_mbr_data,
    output logic              MAC_mbr_we
);

    localparam logic              HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = wait_load_value(WAIT_CYCLES);

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic              accept_s;
    logic              cnt_load_s;
    logic              cnt_dec_s;
    logic              cnt_srst_s;
    logic              cnt_zero_s;
    logic              rw_r;
    logic              busy_r;
    logic              done_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic              mbr_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_din_r;
    logic [DATA_W-1:0] mbr_data_r;

    assign accept_s   = (state_r == ST_IDLE) && MAC_req;
    // Holding the counter clear while idle keeps it at zero between accesses.
    assign cnt_srst_s = (state_r == ST_IDLE);

    wait_counter u_wait_counter (
        .clk      (MAC_clk),
        .rst_n    (MAC_rst_n),
        .srst     (cnt_srst_s),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero_s)
    );

    // Next-state decode and wait-counter control.
    always_comb begin
        next_state_s = state_r;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MAC_req) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (HAS_WAIT) begin
                    next_state_s = ST_WAIT;
                    cnt_load_s   = 1'b1;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_WAIT;
                    cnt_dec_s    = 1'b1;
                end
            end
            ST_ACCESS: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge MAC_clk or negedge MAC_rst_n) begin
        if (!MAC_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture; the memory address and write data registers double as
    // the latched copies, so later input changes cannot reach the memory.
    always_ff @(posedge MAC_clk or negedge MAC_rst_n) begin
        if (!MAC_rst_n) begin
            rw_r       <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            rw_r       <= MAC_rw;
            mem_addr_r <= MAC_addr;
            mem_din_r  <= MAC_wdata;
        end else if (next_state_s == ST_IDLE) begin
            rw_r       <= rw_r;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= mem_din_r;
        end else begin
            rw_r       <= rw_r;
            mem_addr_r <= mem_addr_r;
            mem_din_r  <= mem_din_r;
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge MAC_clk or negedge MAC_rst_n) begin
        if (!MAC_rst_n) begin
            busy_r   <= 1'b0;
            mem_en_r <= 1'b0;
            done_r   <= 1'b0;
            mem_we_r <= 1'b0;
            mbr_we_r <= 1'b0;
        end else begin
            busy_r   <= (next_state_s != ST_IDLE);
            mem_en_r <= (next_state_s != ST_IDLE);
            done_r   <= (next_state_s == ST_DONE);
            mem_we_r <= (next_state_s == ST_ACCESS) && rw_r;
            // Leaving ACCESS on a read: the MBR load lands in DONE.
            mbr_we_r <= (state_r == ST_ACCESS) && !rw_r;
        end
    end

    // Read data capture; only reads update it, so it holds across writes.
    always_ff @(posedge MAC_clk or negedge MAC_rst_n) begin
        if (!MAC_rst_n) begin
            mbr_data_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_ACCESS) && !rw_r) begin
            mbr_data_r <= MAC_mem_dout;
        end else begin
            mbr_data_r <= mbr_data_r;
        end
    end

    assign MAC_busy     = busy_r;
    assign MAC_done     = done_r;
    assign MAC_mem_en   = mem_en_r;
    assign MAC_mem_we   = mem_we_r;
    assign MAC_mem_addr = mem_addr_r;
    assign MAC_mem_din  = mem_din_r;
    assign MAC_mbr_data = mbr_data_r;
    assign MAC_mbr_we   = mbr_we_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a WAIT_CYCLES=2 instance (dut)
// and a WAIT_CYCLES=0 instance (dut0) share data inputs and reset.
module tb_mem_access_ctrl;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_n, req, req0, rw;
    logic [7:0] addr, wdata, mem_dout;
    logic       busy, done, mem_en, mem_we, mbr_we;
    logic [7:0] mem_addr, mem_din, mbr_data;
    logic       z_busy, z_done, z_mem_en, z_mem_we, z_mbr_we;
    logic [7:0] z_mem_addr, z_mem_din, z_mbr_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .MAC_clk(clk), .MAC_rst_n(rst_n), .MAC_req(req), .MAC_rw(rw),
        .MAC_addr(addr), .MAC_wdata(wdata), .MAC_busy(busy), .MAC_done(done),
        .MAC_mem_en(mem_en), .MAC_mem_we(mem_we), .MAC_mem_addr(mem_addr),
        .MAC_mem_din(mem_din), .MAC_mem_dout(mem_dout),
        .MAC_mbr_data(mbr_data), .MAC_mbr_we(mbr_we)
    );

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .MAC_clk(clk), .MAC_rst_n(rst_n), .MAC_req(req0), .MAC_rw(rw),
        .MAC_addr(addr), .MAC_wdata(wdata), .MAC_busy(z_busy), .MAC_done(z_done),
        .MAC_mem_en(z_mem_en), .MAC_mem_we(z_mem_we), .MAC_mem_addr(z_mem_addr),
        .MAC_mem_din(z_mem_din), .MAC_mem_dout(mem_dout),
        .MAC_mbr_data(z_mbr_data), .MAC_mbr_we(z_mbr_we)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_done"}, done, 1'b0);
        check1({name, "_mem_en"}, mem_en, 1'b0);
        check1({name, "_mem_we"}, mem_we, 1'b0);
        check1({name, "_mbr_we"}, mbr_we, 1'b0);
        check8({name, "_mem_addr"}, mem_addr, 8'h00);
        check8({name, "_mem_din"}, mem_din, 8'h00);
        check8({name, "_mbr_data"}, mbr_data, 8'h00);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] dout;
        int         we_cnt;
        int         mbrwe_cnt;
        logic [7:0] mbr;
    } vec_t;

    vec_t vecs[6];

    // One transaction on dut; inputs are scrambled right after acceptance.
    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc = 0, done_cnt = 0, we_cnt = 0, mbrwe_cnt = 0;
        int en_cnt = 0, bad = 0, both = 0;
        rw = v.rw; addr = v.addr; wdata = v.wdata; mem_dout = v.dout; req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req = 1'b0; addr = ~v.addr; wdata = ~v.wdata; rw = ~v.rw;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (mem_en) begin
                en_cnt++;
                if (mem_addr !== v.addr) bad++;
            end
            if (mem_we) begin
                we_cnt++;
                if (mem_din !== v.wdata) bad++;
            end
            if (mbr_we) begin
                mbrwe_cnt++;
                if (mbr_data !== v.dout) bad++;
            end
            if (mem_we && mbr_we) both++;
        end
        checki($sformatf("vec%0d_done_cycle", idx), done_cyc, 3 + W);
        checki($sformatf("vec%0d_done_count", idx), done_cnt, 1);
        checki($sformatf("vec%0d_en_cycles", idx), en_cnt, 3 + W);
        checki($sformatf("vec%0d_mem_we_count", idx), we_cnt, v.we_cnt);
        checki($sformatf("vec%0d_mbr_we_count", idx), mbrwe_cnt, v.mbrwe_cnt);
        checki($sformatf("vec%0d_addr_data_errs", idx), bad, 0);
        checki($sformatf("vec%0d_we_overlap", idx), both, 0);
        check8($sformatf("vec%0d_mbr_data", idx), mbr_data, v.mbr);
    endtask

    // One transaction on dut0 (no wait states).
    task automatic run_w0(input logic r_w, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] d);
        int done_cyc = 0, en_cnt = 0, we_cyc = 0, mbrwe_cnt = 0, bad = 0;
        rw = r_w; addr = a; wdata = wd; mem_dout = d; req0 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0 = 1'b0;
            if (z_done && done_cyc == 0) done_cyc = c;
            if (z_busy) en_cnt++;
            if (z_mem_en && z_mem_addr !== a) bad++;
            if (z_mem_we) begin
                we_cyc = c;
                if (z_mem_din !== wd) bad++;
            end
            if (z_mbr_we) mbrwe_cnt++;
        end
        checki("w0_done_cycle", done_cyc, 3);
        checki("w0_busy_cycles", en_cnt, 3);
        checki("w0_addr_din_errs", bad, 0);
        checki("w0_mem_we_cycle", we_cyc, r_w ? 2 : 0);
        checki("w0_mbr_we_count", mbrwe_cnt, r_w ? 0 : 1);
        if (!r_w) check8("w0_mbr_data", z_mbr_data, d);
    endtask

    // Reference model state: offset d counts cycles since acceptance.
    bit         m_active;
    int         m_d;
    logic       m_rw;
    logic [7:0] m_addr, m_wdata, m_mbr;

    task automatic model_step();
        if (m_active) begin
            m_d++;
            if (m_d == 4 + W) m_active = 1'b0;
            else if (m_d == 3 + W && !m_rw) m_mbr = mem_dout;
        end else if (req) begin
            m_active = 1'b1; m_d = 1; m_rw = rw; m_addr = addr; m_wdata = wdata;
        end
    endtask

    task automatic model_compare();
        logic exp_we;
        exp_we = m_active && m_rw && (m_d == 2 + W);
        check1("rnd_busy", busy, m_active);
        check1("rnd_mem_en", mem_en, m_active);
        check1("rnd_done", done, m_active && (m_d == 3 + W));
        check1("rnd_mem_we", mem_we, exp_we);
        check1("rnd_mbr_we", mbr_we, m_active && !m_rw && (m_d == 3 + W));
        check8("rnd_mbr_data", mbr_data, m_mbr);
        if (m_active) check8("rnd_mem_addr", mem_addr, m_addr);
        if (exp_we) check8("rnd_mem_din", mem_din, m_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, mbrwe_cnt, rises, high_cycles, last_rise, bad_gap;
        logic prev_done;

        vecs[0] = '{1'b0, 8'h1A, 8'h00, 8'h5C, 0, 1, 8'h5C};
        vecs[1] = '{1'b1, 8'h20, 8'hA7, 8'h11, 1, 0, 8'h5C};
        vecs[2] = '{1'b0, 8'hFF, 8'h33, 8'h00, 0, 1, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h77, 1, 0, 8'h00};
        vecs[4] = '{1'b0, 8'h01, 8'h00, 8'hFF, 0, 1, 8'hFF};
        vecs[5] = '{1'b0, 8'h80, 8'h55, 8'h3C, 0, 1, 8'h3C};

        rst_n = 1'b0; req = 1'b0; req0 = 1'b0; rw = 1'b0;
        addr = 8'h00; wdata = 8'h00; mem_dout = 8'h00;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        run_w0(1'b0, 8'h33, 8'h00, 8'h96);
        run_w0(1'b1, 8'h44, 8'h69, 8'h12);

        // Address changed to 0xFF during WAIT must not reach the memory.
        rw = 1'b0; addr = 8'h1A; mem_dout = 8'hC3; req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) req = 1'b0;
            if (c == 2) addr = 8'hFF;
            if (c >= 2 && c <= 5) check8($sformatf("addr_hold_c%0d", c), mem_addr, 8'h1A);
        end
        check8("addr_hold_mbr", mbr_data, 8'hC3);

        // Reset while in WAIT aborts the read.
        rw = 1'b0; addr = 8'h1A; mem_dout = 8'h5C; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        check1("wait_rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("wait_rst");
        #1 rst_n = 1'b1;
        done_cnt = 0; mbrwe_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (mbr_we) mbrwe_cnt++;
        end
        checki("wait_rst_done_count", done_cnt, 0);
        checki("wait_rst_mbr_we_count", mbrwe_cnt, 0);
        check8("wait_rst_mbr_data", mbr_data, 8'h00);

        // First edge after reset release accepts a request.
        pulse_reset();
        req = 1'b1; rw = 1'b1; addr = 8'h42; wdata = 8'h24;
        @(posedge clk); #1;
        req = 1'b0;
        check1("post_rst_accept", busy, 1'b1);
        for (int c = 0; c < 6; c++) @(posedge clk);
        #1;
        check1("post_rst_idle", busy, 1'b0);

        // Request held for 20 edges: one transaction every 4+W cycles.
        rw = 1'b0; addr = 8'h10; mem_dout = 8'h99; req = 1'b1;
        rises = 0; high_cycles = 0; last_rise = 0; bad_gap = 0; prev_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 20) req = 1'b0;
            if (done) begin
                high_cycles++;
                if (!prev_done) begin
                    if (rises == 0) checki("held_first_done", c, 3 + W);
                    else if (c - last_rise != 4 + W) bad_gap++;
                    rises++;
                    last_rise = c;
                end
            end
            prev_done = done;
        end
        checki("held_done_pulses", rises, 4);
        checki("held_done_cycles", high_cycles, 4);
        checki("held_bad_intervals", bad_gap, 0);

        // Randomised run against the transaction-level model.
        pulse_reset();
        m_active = 1'b0; m_d = 0; m_rw = 1'b0; m_addr = 8'h00; m_wdata = 8'h00; m_mbr = 8'h00;
        for (int c = 0; c < 500; c++) begin
            req = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            addr = 8'($urandom);
            wdata = 8'($urandom);
            mem_dout = 8'($urandom);
            @(posedge clk);
            model_step();
            #1;
            model_compare();
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                check1("rnd_rst_busy", busy, 1'b0);
                check1("rnd_rst_done", done, 1'b0);
                check1("rnd_rst_mem_we", mem_we, 1'b0);
                check8("rnd_rst_mbr_data", mbr_data, 8'h00);
                m_active = 1'b0; m_mbr = 8'h00;
                #1 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
